// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_pkg
// Purpose  : Shared state encoding and parity constants for the UART receiver.
// Revision : 1.0 - initial release
// ============================================================================
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/uart_rx_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_ctrl_if
// Purpose  : Bundle between the receive controller and its line/sampler/deserializer side.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_rx_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  RX_IN;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [5:0]            Prescale;
    logic                  sampled_bit;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  dat_samp_en;
    logic                  deser_en;
    logic [5:0]            edge_count;
    logic [3:0]            bit_count;
    logic                  data_valid;
    logic                  par_err;
    logic                  stp_err;
    logic                  busy;

    modport master (
        output RX_IN, PAR_EN, PAR_TYP, Prescale, sampled_bit, P_DATA,
        input  dat_samp_en, deser_en, edge_count, bit_count,
               data_valid, par_err, stp_err, busy
    );

    modport slave (
        input  RX_IN, PAR_EN, PAR_TYP, Prescale, sampled_bit, P_DATA,
        output dat_samp_en, deser_en, edge_count, bit_count,
               data_valid, par_err, stp_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_edge_bit_cnt.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_edge_bit_cnt
// Purpose  : Oversampling edge counter and bit index counter for one frame.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_edge_bit_cnt (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       count_en,
    input  wire logic [5:0] Prescale,
    output logic      [5:0] edge_count,
    output logic      [3:0] bit_count,
    output logic            last_edge
);
    logic [5:0] edge_max;

    assign edge_max  = 6'(Prescale - 6'd1);
    assign last_edge = count_en && (edge_count == edge_max);

    // Counters sit at zero while idle so a new start always begins at edge 0, bit 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_count <= 6'd0;
            bit_count  <= 4'd0;
        end else if (!count_en) begin
            edge_count <= 6'd0;
            bit_count  <= 4'd0;
        end else if (last_edge) begin
            edge_count <= 6'd0;
            bit_count  <= bit_count + 4'd1;
        end else begin
            edge_count <= edge_count + 6'd1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_ctrl
// Purpose  : UART receive frame sequencer: start detect, bit timing, parity/stop checks.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  wire logic     CLK,
    input  wire logic     RST,
    uart_rx_ctrl_if.slave rx
);
    generate
        if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_width
            $error("uart_rx_ctrl: DATA_WIDTH must be 5..9");
        end
    endgenerate

    rx_state_e  state;
    logic       busy;
    logic       deser_en;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;
    logic       brk;
    logic       last_edge;
    logic       par_expected;
    logic [5:0] edge_count;
    logic [3:0] bit_count;

    uart_rx_edge_bit_cnt u_cnt (
        .clk        (CLK),
        .rst        (RST),
        .count_en   (busy),
        .Prescale   (rx.Prescale),
        .edge_count (edge_count),
        .bit_count  (bit_count),
        .last_edge  (last_edge)
    );

    assign par_expected = (^rx.P_DATA) ^ (rx.PAR_TYP == PAR_ODD);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            busy       <= 1'b0;
            deser_en   <= 1'b0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            brk        <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            case (state)
                IDLE: begin
                    // A stop bit sampled low arms brk so a held-low line is not a new start.
                    if (brk) begin
                        if (rx.RX_IN) begin
                            brk <= 1'b0;
                        end
                    end else if (!rx.RX_IN) begin
                        state   <= START;
                        busy    <= 1'b1;
                        par_err <= 1'b0;
                        stp_err <= 1'b0;
                    end
                end
                START: begin
                    if (last_edge) begin
                        if (!rx.sampled_bit) begin
                            state    <= DATA;
                            deser_en <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (last_edge && (bit_count == 4'(DATA_WIDTH))) begin
                        deser_en <= 1'b0;
                        state    <= rx.PAR_EN ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    if (last_edge) begin
                        par_err <= (rx.sampled_bit != par_expected);
                        state   <= STOP;
                    end
                end
                STOP: begin
                    if (last_edge) begin
                        stp_err    <= ~rx.sampled_bit;
                        data_valid <= ~par_err & rx.sampled_bit;
                        brk        <= ~rx.sampled_bit;
                        state      <= IDLE;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    deser_en <= 1'b0;
                end
            endcase
        end
    end

    assign rx.dat_samp_en = busy;
    assign rx.busy        = busy;
    assign rx.deser_en    = deser_en;
    assign rx.edge_count  = edge_count;
    assign rx.bit_count   = bit_count;
    assign rx.data_valid  = data_valid;
    assign rx.par_err     = par_err;
    assign rx.stp_err     = stp_err;
endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_ctrl
// Purpose  : Self-checking bench for uart_rx_ctrl with line, sampler and deserializer models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_ctrl;

    typedef struct {
        logic [7:0] data;
        bit         pe;
        bit         pt;
        bit         flip;
        bit         stp;
        int         P;
        int         low;
        bit         ev;
        bit         eperr;
        bit         eserr;
        int         ecyc;
        int         edeser;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] pdata;
    int         cyc = 0;
    int         ncomp = 0;
    int         nfail = 0;

    uart_rx_ctrl_if #(.DATA_WIDTH(8)) ifc ();

    uart_rx_ctrl #(.DATA_WIDTH(8)) dut (
        .CLK (clk),
        .RST (rst),
        .rx  (ifc.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Sampler sees the line directly; deserializer shifts LSB-first on each data last edge.
    assign ifc.sampled_bit = ifc.RX_IN;
    assign ifc.P_DATA      = pdata;
    always @(posedge clk or posedge rst) begin
        if (rst)
            pdata <= 8'h00;
        else if (ifc.deser_en && ifc.edge_count == 6'(ifc.Prescale - 6'd1))
            pdata <= {ifc.RX_IN, pdata[7:1]};
    end

    task automatic check(input string nm, input int act, input int exp);
        ncomp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic frame_t model(input logic [7:0] d, input bit pe, input bit pt,
                                     input bit flip, input bit stp, input int P, input int low);
        frame_t f;
        f.data = d; f.pe = pe; f.pt = pt; f.flip = flip; f.stp = stp; f.P = P; f.low = low;
        f.eperr  = pe && flip;
        f.eserr  = !stp;
        f.ev     = stp && !f.eperr;
        f.ecyc   = (pe ? 11 : 10) * P + 1;
        f.edeser = 8 * P;
        return f;
    endfunction

    // Entered at the negedge of cycle 0 (the cycle IDLE first sees the line low).
    task automatic run_frame(input frame_t f, input int tail,
                             output int vabs, output int vrel, output int nv, output int ndeser,
                             output int pd, output int perr, output int serr,
                             output int busy_bad, output int clr_bad);
        logic bits [0:10];
        int   nbits;
        int   last;
        nbits = f.pe ? 11 : 10;
        bits[0] = 1'b0;
        for (int i = 1; i <= 8; i++) bits[i] = f.data[i-1];
        bits[9]  = (^f.data) ^ f.pt ^ f.flip;
        bits[nbits-1] = f.stp;
        last = nbits * f.P + 1 + f.low + tail;
        vabs = -1; vrel = -1; nv = 0; ndeser = 0; pd = -1; busy_bad = 0; clr_bad = 0;
        ifc.PAR_EN   = f.pe;
        ifc.PAR_TYP  = f.pt;
        ifc.Prescale = 6'(f.P);
        ifc.RX_IN    = 1'b0;
        for (int n = 1; n <= last; n++) begin
            @(negedge clk);
            if (ifc.data_valid) begin
                nv++; vrel = n; vabs = cyc; pd = int'(ifc.P_DATA);
            end
            if (ifc.deser_en) ndeser++;
            if (n == 1 && (ifc.par_err || ifc.stp_err)) clr_bad = 1;
            if (n > nbits * f.P + 1 && n <= nbits * f.P + 1 + f.low && ifc.busy) busy_bad = 1;
            for (int j = 1; j < nbits; j++)
                if (n == j * f.P + 1) ifc.RX_IN = bits[j];
            if (n == nbits * f.P + 1 + f.low) ifc.RX_IN = 1'b1;
        end
        perr = int'(ifc.par_err);
        serr = int'(ifc.stp_err);
    endtask

    task automatic apply(input string nm, input frame_t f, input int tail, output int vabs);
        int vrel, nv, ndeser, pd, perr, serr, busy_bad, clr_bad;
        run_frame(f, tail, vabs, vrel, nv, ndeser, pd, perr, serr, busy_bad, clr_bad);
        check({nm, "_npulse"}, nv, f.ev ? 1 : 0);
        if (f.ev) begin
            check({nm, "_vcycle"}, vrel, f.ecyc);
            check({nm, "_pdata"}, pd, int'(f.data));
        end
        check({nm, "_par_err"}, perr, int'(f.eperr));
        check({nm, "_stp_err"}, serr, int'(f.eserr));
        check({nm, "_deser_cycles"}, ndeser, f.edeser);
        check({nm, "_flags_cleared_on_start"}, clr_bad, 0);
        check({nm, "_no_busy_in_break"}, busy_bad, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_t tbl [6];
        frame_t f;
        int     v1, v2, hit;
        int     dv_cnt, err_seen;
        int     plist [3];

        plist[0] = 8; plist[1] = 16; plist[2] = 32;
        //        data   pe pt fl stp P   low ev perr serr ecyc edeser
        tbl[0] = '{8'hA5, 0, 0, 0, 1, 8,  0,  1, 0,   0,   81,  64};
        tbl[1] = '{8'h07, 1, 0, 1, 1, 8,  0,  0, 1,   0,   0,   64};
        tbl[2] = '{8'h07, 1, 1, 0, 1, 16, 0,  1, 0,   0,   177, 128};
        tbl[3] = '{8'h5A, 0, 0, 0, 0, 8,  200, 0, 0,  1,   0,   64};
        tbl[4] = '{8'hFF, 1, 0, 0, 1, 32, 0,  1, 0,   0,   353, 256};
        tbl[5] = '{8'h00, 0, 0, 0, 1, 16, 0,  1, 0,   0,   161, 128};

        ifc.RX_IN = 1'b1; ifc.PAR_EN = 1'b0; ifc.PAR_TYP = 1'b0; ifc.Prescale = 6'd8;
        repeat (2) @(negedge clk);
        check("reset_outputs",
              int'({ifc.dat_samp_en, ifc.deser_en, ifc.edge_count, ifc.bit_count,
                    ifc.data_valid, ifc.par_err, ifc.stp_err, ifc.busy}), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            apply($sformatf("tbl%0d", i), tbl[i], 2, v1);
        end

        // Start glitch: line low for three cycles, sampler reads 1 at the start last edge.
        ifc.Prescale = 6'd16; ifc.PAR_EN = 1'b0; ifc.RX_IN = 1'b0;
        dv_cnt = 0; err_seen = 0;
        for (int n = 1; n <= 24; n++) begin
            @(negedge clk);
            if (ifc.data_valid) dv_cnt++;
            if (ifc.par_err || ifc.stp_err) err_seen++;
            if (n == 1)  check("glitch_start_counts", int'({ifc.busy, ifc.edge_count, ifc.bit_count}), 1024);
            if (n == 5)  check("glitch_edge4", int'(ifc.edge_count), 4);
            if (n == 16) check("glitch_busy_at_last_edge", int'({ifc.busy, ifc.edge_count}), 64 + 15);
            if (n == 17) check("glitch_back_to_idle", int'(ifc.busy), 0);
            if (n == 3)  ifc.RX_IN = 1'b1;
        end
        check("glitch_no_pulse", dv_cnt, 0);
        check("glitch_no_error", err_seen, 0);

        // Back-to-back frames at Prescale 32.
        apply("b2b_first", model(8'h3C, 0, 0, 0, 1, 32, 0), 0, v1);
        apply("b2b_second", model(8'hC3, 0, 0, 0, 1, 32, 0), 2, v2);
        check("b2b_pulse_spacing", v2 - v1, 321);

        // Reset in the middle of data bit 4, then a clean frame.
        f = model(8'h55, 0, 0, 0, 1, 8, 0);
        ifc.Prescale = 6'd8; ifc.PAR_EN = 1'b0; ifc.RX_IN = 1'b0;
        hit = 0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (ifc.bit_count == 4'd4 && ifc.deser_en) begin
                hit = 1;
                break;
            end
            for (int j = 1; j < 10; j++)
                if (n == j * 8 + 1) ifc.RX_IN = (j <= 8) ? f.data[j-1] : 1'b1;
        end
        check("rst_reached_bit4", hit, 1);
        rst = 1'b1;
        #1;
        check("rst_midframe_outputs",
              int'({ifc.dat_samp_en, ifc.deser_en, ifc.edge_count, ifc.bit_count,
                    ifc.data_valid, ifc.par_err, ifc.stp_err, ifc.busy}), 0);
        @(negedge clk);
        rst = 1'b0; ifc.RX_IN = 1'b1;
        repeat (3) @(negedge clk);
        apply("after_rst_55", f, 2, v1);

        // Randomized frames against the reference model.
        for (int k = 0; k < 20; k++) begin
            logic [7:0] d;
            bit pe, pt, fl, stp;
            int P, low;
            d   = 8'($urandom);
            pe  = 1'($urandom);
            pt  = 1'($urandom);
            fl  = ($urandom_range(0, 3) == 0);
            stp = ($urandom_range(0, 4) != 0);
            P   = plist[$urandom_range(0, 2)];
            low = stp ? 0 : int'($urandom_range(1, 40));
            apply($sformatf("rnd%0d", k), model(d, pe, pt, fl, stp, P, low), 2, v1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end
endmodule
`default_nettype wire
